mem_sequencer: RTL and testbench

Upstream access sequencer for the 2K x 16 weight/activation scratch memory. Accepts a valid/ready input stream and writes it to consecutive memory addresses, then on command reads a block back and presents it as a valid/ready output stream. It owns the memory's `wr_en`/`rd_en`/`address`/`data_in` pins, consumes its `data_out`/`output_ready`, and paces every access to the memory's 2-cycle write and 3-cycle read turnaround.

---
 rtl/mem_sequencer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mem_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer: moves a valid/ready stream into the 2K x 16 scratch memory and reads blocks back out,
// pacing the 2-cycle write / 3-cycle read turnaround. Define MEMSEQ_CHECKSUM_EN for running checksums.
module mem_sequencer #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 16,
   parameter int RD_TIMEOUT = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load_start,
   input  logic              i_rd_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W:0]   i_length,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_last,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_wr_en,
   output logic              o_mem_rd_en,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_rd_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [DATA_W-1:0] o_chk_wr_sum,
   output logic [DATA_W-1:0] o_chk_rd_sum
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR_ACCEPT = 3'd1,
      S_WR_GAP    = 3'd2,
      S_RD_ISSUE  = 3'd3,
      S_RD_WAIT   = 3'd4,
      S_RD_HOLD   = 3'd5
   } state_t;

   localparam int              TMR_W    = $clog2(RD_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RD_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W:0]     r_len;
   logic [ADDR_W:0]     r_idx;
   logic [TMR_W-1:0]    r_timer;

   logic                r_in_ready, r_out_valid, r_out_last;
   logic                r_mem_wr_en, r_mem_rd_en, r_busy, r_done, r_err;
   logic [DATA_W-1:0]   r_out_data, r_mem_wdata;
   logic [ADDR_W-1:0]   r_mem_addr;

   logic                w_in_ready_nxt, w_out_valid_nxt, w_out_last_nxt;
   logic                w_mem_wr_en_nxt, w_mem_rd_en_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
   logic [DATA_W-1:0]   w_out_data_nxt, w_mem_wdata_nxt;
   logic [ADDR_W-1:0]   w_mem_addr_nxt;

   logic                w_ld_go, w_rd_go, w_len_zero, w_len_bad, w_len_ok;
   logic                w_wr_hs, w_rd_cap, w_rd_to, w_out_hs, w_blk_last, w_cap_last;
   logic [ADDR_W-1:0]   w_addr;

   // Load wins when both start pulses arrive together; starts are only seen in IDLE.
   assign w_ld_go    = (r_state == S_IDLE) && i_load_start;
   assign w_rd_go    = (r_state == S_IDLE) && !i_load_start && i_rd_start;
   assign w_len_zero = (i_length == LEN_ZERO);
   assign w_len_bad  = (i_length > MAX_LEN);
   assign w_len_ok   = !w_len_zero && !w_len_bad;

   assign w_addr     = r_base + r_idx[ADDR_W-1:0];
   assign w_wr_hs    = (r_state == S_WR_ACCEPT) && r_in_ready && i_in_valid;
   assign w_rd_cap   = (r_state == S_RD_WAIT) && i_mem_rd_ready;
   assign w_rd_to    = (r_state == S_RD_WAIT) && !i_mem_rd_ready && (r_timer == TMR_LAST);
   assign w_out_hs   = (r_state == S_RD_HOLD) && r_out_valid && i_out_ready;
   assign w_blk_last = (r_idx == r_len);
   assign w_cap_last = ((r_idx + LEN_ONE) == r_len);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_ld_go && w_len_ok) begin
               w_state_nxt = S_WR_ACCEPT;
            end else if (w_rd_go && w_len_ok) begin
               w_state_nxt = S_RD_ISSUE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WR_ACCEPT: begin
            if (w_wr_hs) begin
               w_state_nxt = S_WR_GAP;
            end else begin
               w_state_nxt = S_WR_ACCEPT;
            end
         end
         S_WR_GAP: begin
            if (w_blk_last) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WR_ACCEPT;
            end
         end
         S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
         S_RD_WAIT: begin
            if (w_rd_cap) begin
               w_state_nxt = S_RD_HOLD;
            end else if (w_rd_to) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RD_WAIT;
            end
         end
         S_RD_HOLD: begin
            if (w_out_hs && w_blk_last) begin
               w_state_nxt = S_IDLE;
            end else if (w_out_hs) begin
               w_state_nxt = S_RD_ISSUE;
            end else begin
               w_state_nxt = S_RD_HOLD;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode: next values for every registered output; strobes coincide with WR_GAP / RD_ISSUE
   always_comb begin
      w_in_ready_nxt  = (w_state_nxt == S_WR_ACCEPT);
      w_busy_nxt      = (w_state_nxt != S_IDLE);
      w_mem_wr_en_nxt = w_wr_hs;
      w_mem_rd_en_nxt = (w_state_nxt == S_RD_ISSUE);
      w_done_nxt      = ((w_ld_go || w_rd_go) && w_len_zero)
                        || ((r_state == S_WR_GAP) && w_blk_last)
                        || (w_out_hs && w_blk_last);

      if (w_rd_go && w_len_ok) begin
         w_mem_addr_nxt = i_base_addr;
      end else if (w_wr_hs || (w_out_hs && !w_blk_last)) begin
         w_mem_addr_nxt = w_addr;
      end else begin
         w_mem_addr_nxt = r_mem_addr;
      end

      if (w_wr_hs) begin
         w_mem_wdata_nxt = i_in_data;
      end else begin
         w_mem_wdata_nxt = r_mem_wdata;
      end

      if (w_rd_cap) begin
         w_out_valid_nxt = 1'b1;
         w_out_last_nxt  = w_cap_last;
         w_out_data_nxt  = i_mem_rdata;
      end else if (w_out_hs) begin
         w_out_valid_nxt = 1'b0;
         w_out_last_nxt  = 1'b0;
         w_out_data_nxt  = r_out_data;
      end else begin
         w_out_valid_nxt = r_out_valid;
         w_out_last_nxt  = r_out_last;
         w_out_data_nxt  = r_out_data;
      end

      if (w_ld_go || w_rd_go) begin
         w_err_nxt = w_len_bad;
      end else if (w_rd_to) begin
         w_err_nxt = 1'b1;
      end else begin
         w_err_nxt = r_err;
      end
   end

   // Output registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= {DATA_W{1'b0}};
         r_mem_addr  <= {ADDR_W{1'b0}};
         r_mem_wdata <= {DATA_W{1'b0}};
         r_mem_wr_en <= 1'b0;
         r_mem_rd_en <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_last  <= w_out_last_nxt;
         r_out_data  <= w_out_data_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_wr_en <= w_mem_wr_en_nxt;
         r_mem_rd_en <= w_mem_rd_en_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_err       <= w_err_nxt;
      end
   end

   // Block bookkeeping: index advances per accepted write word or captured read word
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_base  <= {ADDR_W{1'b0}};
         r_len   <= LEN_ZERO;
         r_idx   <= LEN_ZERO;
         r_timer <= {TMR_W{1'b0}};
      end else begin
         if ((w_ld_go || w_rd_go) && w_len_ok) begin
            r_base <= i_base_addr;
            r_len  <= i_length;
            r_idx  <= LEN_ZERO;
         end else if (w_wr_hs || w_rd_cap) begin
            r_idx <= r_idx + LEN_ONE;
         end
         if (r_state == S_RD_WAIT) begin
            r_timer <= r_timer + TMR_ONE;
         end else begin
            r_timer <= {TMR_W{1'b0}};
         end
      end
   end

`ifdef MEMSEQ_CHECKSUM_EN
   logic [DATA_W-1:0] r_wr_sum, r_rd_sum;

   // Running sums over written words and handshaken output words
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_sum <= {DATA_W{1'b0}};
         r_rd_sum <= {DATA_W{1'b0}};
      end else begin
         if (w_ld_go) begin
            r_wr_sum <= {DATA_W{1'b0}};
         end else if (r_mem_wr_en) begin
            r_wr_sum <= r_wr_sum + r_mem_wdata;
         end
         if (w_rd_go) begin
            r_rd_sum <= {DATA_W{1'b0}};
         end else if (w_out_hs) begin
            r_rd_sum <= r_rd_sum + r_out_data;
         end
      end
   end

   assign o_chk_wr_sum = r_wr_sum;
   assign o_chk_rd_sum = r_rd_sum;
`else
   assign o_chk_wr_sum = {DATA_W{1'b0}};
   assign o_chk_rd_sum = {DATA_W{1'b0}};
`endif

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_last  = r_out_last;
   assign o_out_data  = r_out_data;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_wr_en = r_mem_wr_en;
   assign o_mem_rd_en = r_mem_rd_en;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer: write/read queues filled at stimulus time, popped on strobes/handshakes.
module tb_mem_sequencer;
   localparam int AW = 11;
   localparam int DW = 16;
`ifdef MEMSEQ_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_load_start = 1'b0, i_rd_start = 1'b0;
   logic [AW-1:0] i_base_addr = '0;
   logic [AW:0]   i_length = '0;
   logic          i_in_valid = 1'b0, i_out_ready = 1'b0;
   logic [DW-1:0] i_in_data = '0;
   logic [DW-1:0] i_mem_rdata = '0;
   logic          i_mem_rd_ready = 1'b0;
   logic          o_in_ready, o_out_valid, o_out_last, o_mem_wr_en, o_mem_rd_en, o_busy, o_done, o_err;
   logic [DW-1:0] o_out_data, o_mem_wdata, o_chk_wr_sum, o_chk_rd_sum;
   logic [AW-1:0] o_mem_addr;

   always #5 i_clk = ~i_clk;

   mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(8)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_load_start(i_load_start), .i_rd_start(i_rd_start),
      .i_base_addr(i_base_addr), .i_length(i_length), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_data(i_in_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
      .o_out_last(o_out_last), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wr_en(o_mem_wr_en),
      .o_mem_rd_en(o_mem_rd_en), .i_mem_rdata(i_mem_rdata), .i_mem_rd_ready(i_mem_rd_ready), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err), .o_chk_wr_sum(o_chk_wr_sum), .o_chk_rd_sum(o_chk_rd_sum));

   int n_vec = 0;
   int n_miss = 0;
   logic [DW-1:0] model_mem [0:2047];
   logic [DW-1:0] ref_mem [0:2047];
   logic [DW-1:0] src [0:7];
   logic          mem_respond = 1'b1;
   logic          rd_pend = 1'b0;
   logic [AW-1:0] pend_addr = '0;
   logic [AW+DW-1:0] wq[$];
   logic [DW:0]      rq[$];

   // Memory model: stores strobed writes, answers a read strobe with data one cycle later
   always @(posedge i_clk) begin
      #1;
      i_mem_rd_ready = 1'b0;
      if (rd_pend) begin
         i_mem_rd_ready = 1'b1;
         i_mem_rdata = model_mem[pend_addr];
      end
      rd_pend = o_mem_rd_en && mem_respond;
      pend_addr = o_mem_addr;
      if (o_mem_wr_en) model_mem[o_mem_addr] = o_mem_wdata;
   end

   task automatic tick;
      @(negedge i_clk);
   endtask

   task automatic test_reset;
      i_reset = 1'b1;
      repeat (3) tick;
      n_vec++; if ({o_in_ready, o_out_valid, o_out_last, o_mem_wr_en, o_mem_rd_en, o_busy, o_done, o_err} !== 8'h00) begin
         n_miss++; $display("FAIL reset_ctrl: got %b want 00000000", {o_in_ready, o_out_valid, o_out_last, o_mem_wr_en, o_mem_rd_en, o_busy, o_done, o_err}); end
      n_vec++; if ({o_mem_addr, o_mem_wdata, o_out_data} !== {(AW+2*DW){1'b0}}) begin
         n_miss++; $display("FAIL reset_data: got %h/%h/%h want 0", o_mem_addr, o_mem_wdata, o_out_data); end
      n_vec++; if ({o_chk_wr_sum, o_chk_rd_sum} !== 32'h0) begin
         n_miss++; $display("FAIL reset_sums: got %h/%h want 0", o_chk_wr_sum, o_chk_rd_sum); end
      i_reset = 1'b0;
      tick;
   endtask

   task automatic do_load(input logic [AW-1:0] base, input int len, input bit both);
      int cyc, last_stb, nstb, k;
      bit hs, got_done;
      logic [DW-1:0] sum;
      logic [AW-1:0] a;
      logic [AW+DW-1:0] exp_w;
      sum = '0;
      for (int i = 0; i < len; i++) begin
         a = base + AW'(i);
         wq.push_back({a, src[i]});
         ref_mem[a] = src[i];
         sum = sum + src[i];
      end
      i_base_addr = base; i_length = (AW+1)'(len); i_load_start = 1'b1; i_rd_start = both;
      tick;
      i_load_start = 1'b0; i_rd_start = 1'b0;
      n_vec++; if ({o_busy, o_in_ready} !== 2'b11) begin
         n_miss++; $display("FAIL load_start: busy/in_ready got %b want 11", {o_busy, o_in_ready}); end
      i_in_valid = 1'b1; i_in_data = src[0];
      k = 0; cyc = 0; last_stb = -100; nstb = 0; got_done = 1'b0;
      while (!got_done && cyc < 100) begin
         n_vec++; if (o_mem_rd_en !== 1'b0) begin n_miss++; $display("FAIL load_rd_en: got %b want 0 at cyc %0d", o_mem_rd_en, cyc); end
         if (o_mem_wr_en) begin
            if (wq.size() == 0) begin
               n_vec++; n_miss++; $display("FAIL load_extra_strobe: addr %h", o_mem_addr);
            end else begin
               exp_w = wq.pop_front();
               n_vec++; if ({o_mem_addr, o_mem_wdata} !== exp_w) begin
                  n_miss++; $display("FAIL load_write: got %h:%h want %h:%h", o_mem_addr, o_mem_wdata, exp_w[AW+DW-1:DW], exp_w[DW-1:0]); end
            end
            if (nstb > 0) begin
               n_vec++; if (cyc - last_stb != 2) begin n_miss++; $display("FAIL load_spacing: got %0d want 2", cyc - last_stb); end
            end
            last_stb = cyc; nstb++;
         end
         if (o_done) begin
            got_done = 1'b1;
            n_vec++; if (nstb != len) begin n_miss++; $display("FAIL load_count: got %0d want %0d", nstb, len); end
            n_vec++; if (cyc != last_stb + 1) begin n_miss++; $display("FAIL load_done_time: got %0d want %0d", cyc, last_stb + 1); end
            n_vec++; if (o_chk_wr_sum !== (CK_EN ? sum : 16'h0)) begin
               n_miss++; $display("FAIL load_sum: got %h want %h", o_chk_wr_sum, CK_EN ? sum : 16'h0); end
         end
         if (!got_done) begin
            hs = o_in_ready && i_in_valid;
            tick; cyc++;
            if (hs) begin
               k++;
               if (k < len) i_in_data = src[k]; else i_in_valid = 1'b0;
            end
         end
      end
      if (!got_done) begin n_vec++; n_miss++; $display("FAIL load_timeout: got no done want done"); end
      i_in_valid = 1'b0;
      wq.delete();
      tick;
      n_vec++; if ({o_busy, o_done} !== 2'b00) begin n_miss++; $display("FAIL load_idle: busy/done got %b want 00", {o_busy, o_done}); end
   endtask

   task automatic do_read(input logic [AW-1:0] base, input int len, input int stall_idx, input int stall_n);
      int cyc, last_stb, last_hs, nstb, nout, stall_left;
      bit hs, got_done, prev_valid, prev_hs;
      logic [DW-1:0] sum, held;
      logic [AW-1:0] a;
      logic [DW:0] exp_r;
      sum = '0;
      for (int i = 0; i < len; i++) begin
         a = base + AW'(i);
         rq.push_back({(i == len - 1), ref_mem[a]});
         sum = sum + ref_mem[a];
      end
      i_base_addr = base; i_length = (AW+1)'(len); i_rd_start = 1'b1; i_out_ready = 1'b1;
      tick;
      i_rd_start = 1'b0;
      cyc = 0; last_stb = -100; last_hs = -100; nstb = 0; nout = 0; stall_left = stall_n;
      got_done = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; held = '0;
      while (!got_done && cyc < 200) begin
         n_vec++; if (o_mem_wr_en !== 1'b0) begin n_miss++; $display("FAIL read_wr_en: got %b want 0", o_mem_wr_en); end
         if (o_mem_rd_en) begin
            if (nstb > 0) begin
               n_vec++; if (cyc != last_hs + 1) begin n_miss++; $display("FAIL read_issue_time: got %0d want %0d", cyc, last_hs + 1); end
            end
            last_stb = cyc; nstb++;
         end
         if (o_out_valid && !prev_valid) begin
            n_vec++; if (cyc != last_stb + 2) begin n_miss++; $display("FAIL read_valid_time: got %0d want %0d", cyc, last_stb + 2); end
         end
         if (o_out_valid && prev_valid && !prev_hs) begin
            n_vec++; if (o_out_data !== held) begin n_miss++; $display("FAIL read_hold: got %h want %h", o_out_data, held); end
         end
         if (o_out_valid) held = o_out_data;
         if (o_done) begin
            got_done = 1'b1;
            n_vec++; if (cyc != last_hs + 1) begin n_miss++; $display("FAIL read_done_time: got %0d want %0d", cyc, last_hs + 1); end
            n_vec++; if (nout != len) begin n_miss++; $display("FAIL read_count: got %0d want %0d", nout, len); end
            n_vec++; if (o_chk_rd_sum !== (CK_EN ? sum : 16'h0)) begin
               n_miss++; $display("FAIL read_sum: got %h want %h", o_chk_rd_sum, CK_EN ? sum : 16'h0); end
         end
         if (o_out_valid && nout == stall_idx && stall_left > 0) begin
            i_out_ready = 1'b0; stall_left--;
         end else begin
            i_out_ready = 1'b1;
         end
         hs = o_out_valid && i_out_ready;
         if (hs) begin
            if (rq.size() == 0) begin
               n_vec++; n_miss++; $display("FAIL read_extra_word: data %h", o_out_data);
            end else begin
               exp_r = rq.pop_front();
               n_vec++; if ({o_out_last, o_out_data} !== exp_r) begin
                  n_miss++; $display("FAIL read_word: got last=%b %h want last=%b %h", o_out_last, o_out_data, exp_r[DW], exp_r[DW-1:0]); end
            end
            nout++; last_hs = cyc;
         end
         prev_valid = o_out_valid; prev_hs = hs;
         if (!got_done) begin tick; cyc++; end
      end
      if (!got_done) begin n_vec++; n_miss++; $display("FAIL read_timeout: got no done want done"); end
      rq.delete();
      tick;
      n_vec++; if ({o_busy, o_done, o_out_valid} !== 3'b000) begin
         n_miss++; $display("FAIL read_idle: busy/done/valid got %b want 000", {o_busy, o_done, o_out_valid}); end
   endtask

   task automatic test_load_read;
      src[0] = 16'h1111; src[1] = 16'h2222; src[2] = 16'h3333; src[3] = 16'h4444;
      do_load(11'h010, 4, 1'b0);
      do_read(11'h010, 4, -1, 0);
   endtask

   task automatic test_wrap;
      src[0] = 16'hA001; src[1] = 16'hB002; src[2] = 16'hC003;
      do_load(11'h7FE, 3, 1'b0);
      do_read(11'h7FE, 3, -1, 0);
   endtask

   task automatic test_read_stall;
      do_read(11'h010, 4, 1, 5);
   endtask

   task automatic test_timeout;
      int stb_cyc, err_cyc, nstb;
      bit seen_done;
      mem_respond = 1'b0;
      i_base_addr = 11'h010; i_length = 12'd2; i_rd_start = 1'b1; i_out_ready = 1'b1;
      tick;
      i_rd_start = 1'b0;
      stb_cyc = -1; err_cyc = -1; nstb = 0; seen_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (o_mem_rd_en) begin nstb++; stb_cyc = c; end
         if (o_done) seen_done = 1'b1;
         if (o_err && err_cyc < 0) err_cyc = c;
         tick;
      end
      n_vec++; if (err_cyc < 0) begin n_miss++; $display("FAIL timeout_err: got err=0 want err=1"); end
      n_vec++; if (err_cyc - stb_cyc < 8 || err_cyc - stb_cyc > 10) begin
         n_miss++; $display("FAIL timeout_delay: got %0d want 8..10", err_cyc - stb_cyc); end
      n_vec++; if (seen_done) begin n_miss++; $display("FAIL timeout_done: got done=1 want 0"); end
      n_vec++; if (nstb != 1) begin n_miss++; $display("FAIL timeout_strobes: got %0d want 1", nstb); end
      n_vec++; if ({o_busy, o_err, o_out_valid} !== 3'b010) begin
         n_miss++; $display("FAIL timeout_idle: busy/err/valid got %b want 010", {o_busy, o_err, o_out_valid}); end
      mem_respond = 1'b1;
   endtask

   task automatic test_bad_length;
      bit bad_seen;
      i_base_addr = 11'h000; i_length = 12'h801; i_load_start = 1'b1;
      tick;
      i_load_start = 1'b0;
      bad_seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (o_mem_wr_en || o_mem_rd_en || o_done || o_busy) bad_seen = 1'b1;
         tick;
      end
      n_vec++; if (bad_seen) begin n_miss++; $display("FAIL badlen_activity: got activity want none"); end
      n_vec++; if (o_err !== 1'b1) begin n_miss++; $display("FAIL badlen_err: got %b want 1", o_err); end
      i_length = 12'h000; i_rd_start = 1'b1;
      tick;
      i_rd_start = 1'b0;
      n_vec++; if ({o_done, o_err, o_busy, o_mem_rd_en} !== 4'b1000) begin
         n_miss++; $display("FAIL zerolen: done/err/busy/rd_en got %b want 1000", {o_done, o_err, o_busy, o_mem_rd_en}); end
      tick;
      n_vec++; if (o_done !== 1'b0) begin n_miss++; $display("FAIL zerolen_pulse: got %b want 0", o_done); end
   endtask

   task automatic test_simultaneous;
      src[0] = 16'h5A5A; src[1] = 16'h0F0F;
      do_load(11'h100, 2, 1'b1);
   endtask

   task automatic test_reset_mid_read;
      bit seen_valid, bad_seen;
      i_base_addr = 11'h010; i_length = 12'd4; i_rd_start = 1'b1; i_out_ready = 1'b0;
      tick;
      i_rd_start = 1'b0;
      seen_valid = 1'b0;
      for (int c = 0; c < 20 && !seen_valid; c++) begin
         if (o_out_valid) seen_valid = 1'b1; else tick;
      end
      n_vec++; if (!seen_valid) begin n_miss++; $display("FAIL rst_mid_setup: got no out_valid want out_valid"); end
      i_reset = 1'b1;
      tick;
      n_vec++; if ({o_in_ready, o_out_valid, o_out_last, o_mem_wr_en, o_mem_rd_en, o_busy, o_done, o_err} !== 8'h00) begin
         n_miss++; $display("FAIL rst_mid_ctrl: got %b want 00000000", {o_in_ready, o_out_valid, o_out_last, o_mem_wr_en, o_mem_rd_en, o_busy, o_done, o_err}); end
      n_vec++; if ({o_mem_addr, o_out_data, o_chk_wr_sum, o_chk_rd_sum} !== {(AW+3*DW){1'b0}}) begin
         n_miss++; $display("FAIL rst_mid_data: got %h/%h/%h/%h want 0", o_mem_addr, o_out_data, o_chk_wr_sum, o_chk_rd_sum); end
      i_reset = 1'b0; i_out_ready = 1'b1;
      bad_seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick;
         if (o_done || o_busy || o_mem_rd_en || o_out_valid) bad_seen = 1'b1;
      end
      n_vec++; if (bad_seen) begin n_miss++; $display("FAIL rst_mid_after: got activity want idle"); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit want completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_load_read;
      test_wrap;
      test_read_stall;
      test_timeout;
      test_bad_length;
      test_simultaneous;
      test_reset_mid_read;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
